fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Pointer, occupancy and handshake controller that turns the team's 512x20 two-port memory (mem_twoport) into a synchronous FIFO.
- Accepts a valid/ready write stream upstream and presents a valid/ready read stream downstream.
- Drives the memory's ra/wa/write/d ports and returns its combinational q as out_data.

Parameters:
- AW, 9, address width; FIFO depth = 2**AW (512).
- DW, 20, data width; must match the memory word width.
- AF_LEVEL, 448, almost_full asserts when count >= AF_LEVEL.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of pointers and occupancy.
- in_valid  in  1  upstream word present.
- in_ready  out  1  FIFO can accept a word.
- in_data  in  DW  upstream word.
- out_valid  out  1  head word available.
- out_ready  in  1  downstream consumes head word.
- out_data  out  DW  head word; equals mem_q.
- mem_ra  out  AW  memory read address (rd_ptr).
- mem_wa  out  AW  memory write address (wr_ptr).
- mem_write  out  1  memory write enable.
- mem_d  out  DW  memory write data (in_data passthrough).
- mem_q  in  DW  memory combinational read data.
- count  out  AW+1  occupancy, 0..512.
- full  out  1  count == 2**AW.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.

Behaviour:
- Clock is clk. Reset is asynchronous and active-low (rst_n); polarity and synchronicity are fixed.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, out_valid=0, in_ready=1.
- mem_write is forced to 0 while rst_n=0.
- Registered state: wr_ptr, rd_ptr (AW bits each) and count (AW+1 bits).
- full, empty and almost_full are decoded from registered count, with no combinational path from inputs.
- in_ready = !full. out_valid = !empty. Both depend only on registered state; no in->out combinational path.
- push = in_valid & in_ready & !flush. pop = out_valid & out_ready & !flush.
- mem_write = push, mem_wa = wr_ptr, mem_d = in_data.
- mem_ra = rd_ptr, out_data = mem_q.
- On push: wr_ptr <= wr_ptr+1, wrapping 511 -> 0 by natural AW-bit overflow.
- On pop: rd_ptr <= rd_ptr+1, with the same wrap.
- count update: push only -> +1; pop only -> -1; push and pop together -> unchanged (both pointers advance).
- Write-to-read latency: a word pushed at edge N is visible on out_data, with out_valid=1, from edge N onward. First-word fall-through is 1 cycle.
- No bypass when empty. The memory read of the written address returns old data before the edge; out_valid is 0 then, so this is harmless.
- Full: in_ready=0, so no push. A pop in the same cycle does not enable a push that cycle; in_ready rises the cycle after.
- Empty: out_valid=0, so no pop. out_ready is ignored.
- flush=1: at the next edge wr_ptr, rd_ptr and count go to 0. mem_write is 0 during the flush cycle. flush overrides push and pop. Memory contents are not cleared.
- rst_n low mid-stream: all state clears immediately (asynchronously). Data in flight is discarded. The first push after rst_n rises writes address 0.
- No overflow or underflow is possible through the handshake. A bench assertion checks count <= 512 and that push is never asserted with full=1.

Decomposition:
- Package fifo_pkg holds: AW and DW defaults; typedef addr_t (logic [AW-1:0]); typedef cnt_t (logic [AW:0]); typedef word_t (logic [DW-1:0]); localparam DEPTH = 2**AW.
- fifo_ctrl is a single module with no sub-module.
- A thin top fifo_top instantiates fifo_ctrl and mem_twoport and is the unit the bench drives.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then release -> count=0, empty=1, in_ready=1, out_valid=0, mem_write never 1.
- Single word: push 0x12345 with out_ready=0 -> next cycle out_valid=1, out_data=0x12345, count=1. Then out_ready=1 for one cycle -> empty=1.
- Fill to full: push 512 words 0..511, out_ready=0.
  - almost_full rises when count reaches 448.
  - full=1 and in_ready=0 at count=512.
  - A 513th in_valid is not written (mem_write stays 0).
- Wrap and ordering: push and pop with random valid/ready for 2000 words -> output sequence equals input sequence. Both pointers pass 511 -> 0 at least 3 times. count matches the scoreboard every cycle.
- Simultaneous push/pop at count=5 -> count stays 5 and both pointers advance by 1. At count=512 with out_ready=1 and in_valid=1 -> count=511, and in_ready=1 the following cycle.
- Flush and mid-op reset:
  - Flush at count=37 with in_valid=out_ready=1 -> next cycle count=0, empty=1, no write that cycle.
  - Async rst_n pulse mid-fill at count=100 -> count=0 immediately; the next push writes mem_wa=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared widths, depth and word types for the 512x20 FIFO controller and its memory.
package fifo_pkg;
  localparam int AW       = 9;
  localparam int DW       = 20;
  localparam int AF_LEVEL = 448;
  localparam int DEPTH    = 2**AW;

  typedef logic [AW-1:0] addr_t;
  typedef logic [AW:0]   cnt_t;
  typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/mem_twoport.sv
// 512x20 two-port memory: synchronous write, combinational read.
module mem_twoport
  import fifo_pkg::*;
(
  input  logic  clk,
  input  addr_t ra,
  input  addr_t wa,
  input  logic  write,
  input  word_t d,
  output word_t q
);

  word_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (write) mem_q[wa] <= d;
  end

  assign q = mem_q[ra];

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy/handshake controller that turns mem_twoport into a synchronous FIFO.
module fifo_ctrl #(
  parameter int AW       = fifo_pkg::AW,
  parameter int DW       = fifo_pkg::DW,
  parameter int AF_LEVEL = fifo_pkg::AF_LEVEL
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] mem_ra,
  output logic [AW-1:0] mem_wa,
  output logic          mem_write,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          almost_full
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(2**AW);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          push, pop;

  // Status flags come only from registered count, so ready/valid never see the inputs.
  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AF_CNT);
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign count       = count_q;

  // rst_n gates the write strobe so the memory is never written while held in reset.
  assign push = in_valid & in_ready & !flush & rst_n;
  assign pop  = out_valid & out_ready & !flush;

  assign mem_write = push;
  assign mem_wa    = wr_ptr_q;
  assign mem_d     = in_data;
  assign mem_ra    = rd_ptr_q;
  assign out_data  = mem_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl paired with mem_twoport.
module tb_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic [8:0]  mem_ra;
  logic [8:0]  mem_wa;
  logic        mem_write;
  logic [19:0] mem_d;
  logic [19:0] mem_q;
  logic [9:0]  count;
  logic        full;
  logic        empty;
  logic        almost_full;

  int n_asrt = 0;
  int n_fail = 0;

  // reference model
  int          m_cnt = 0;
  int          m_wr  = 0;
  int          m_rd  = 0;
  logic [19:0] m_q[$];

  always #5 clk = ~clk;

  fifo_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_ra(mem_ra), .mem_wa(mem_wa), .mem_write(mem_write), .mem_d(mem_d), .mem_q(mem_q),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full)
  );

  mem_twoport u_mem (
    .clk(clk), .ra(mem_ra), .wa(mem_wa), .write(mem_write), .d(mem_d), .q(mem_q)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("count_le_512", int'(count <= 10'd512), 1);
    chk("no_push_when_full", int'(mem_write && full), 0);
    if (!rst_n) chk("no_write_in_reset", int'(mem_write), 0);
  end

  task automatic model_clear();
    m_cnt = 0; m_wr = 0; m_rd = 0;
    m_q.delete();
  endtask

  // One clock of stimulus checked against the model; enters and leaves at posedge+1.
  task automatic cycle(input logic iv, input logic ordy, input logic fl, input logic [19:0] din,
                       output logic did_push, output logic did_pop);
    logic e_push, e_pop;
    in_valid = iv; out_ready = ordy; flush = fl; in_data = din;
    #1;
    e_push = iv && (m_cnt != 512) && !fl;
    e_pop  = ordy && (m_cnt != 0) && !fl;
    chk("mem_write", int'(mem_write), int'(e_push));
    if (e_push) chk("mem_wa", int'(mem_wa), m_wr);
    chk("mem_ra", int'(mem_ra), m_rd);
    if (m_cnt != 0) chk("out_data", int'(out_data), int'(m_q[0]));
    @(posedge clk); #1;
    if (fl) model_clear();
    else begin
      if (e_push) begin m_q.push_back(din); m_wr = (m_wr + 1) % 512; end
      if (e_pop)  begin void'(m_q.pop_front()); m_rd = (m_rd + 1) % 512; end
      m_cnt = m_q.size();
    end
    chk("count", int'(count), m_cnt);
    chk("empty", int'(empty), int'(m_cnt == 0));
    chk("full", int'(full), int'(m_cnt == 512));
    chk("almost_full", int'(almost_full), int'(m_cnt >= 448));
    chk("in_ready", int'(in_ready), int'(m_cnt != 512));
    chk("out_valid", int'(out_valid), int'(m_cnt != 0));
    did_push = e_push;
    did_pop  = e_pop;
  endtask

  typedef struct {
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [19:0] din;
    logic        e_write;
    int          e_wa;
    int          e_cnt;
    logic [19:0] e_data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic dp, dq;
    int   pushed, popped, cyc, ra_wraps, wa_wraps, prev_ra, prev_wa, ra0, wa0;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 20'h12345, 1'b1, 0, 1, 20'h12345};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 20'h00000, 1'b0, 1, 0, 20'h00000};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 20'h0AAAA, 1'b1, 1, 1, 20'h0AAAA};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 20'h0BBBB, 1'b1, 2, 2, 20'h0AAAA};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 20'h0CCCC, 1'b1, 3, 2, 20'h0BBBB};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 20'h00000, 1'b0, 4, 1, 20'h0CCCC};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 20'h0DDDD, 1'b0, 4, 0, 20'h00000};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 20'h00000, 1'b0, 0, 0, 20'h00000};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 20'h0EEEE, 1'b1, 0, 1, 20'h0EEEE};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 20'h00000, 1'b0, 1, 0, 20'h00000};

    // reset held two cycles with in_valid high
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = 20'h3FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_write", int'(mem_write), 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_almost_full", int'(almost_full), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_mem_write", int'(mem_write), 0);

    foreach (vecs[i]) begin
      flush = vecs[i].fl; in_valid = vecs[i].iv; out_ready = vecs[i].ordy; in_data = vecs[i].din;
      #1;
      chk($sformatf("vec%0d_mem_write", i), int'(mem_write), int'(vecs[i].e_write));
      chk($sformatf("vec%0d_mem_wa", i), int'(mem_wa), vecs[i].e_wa);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].e_cnt);
      chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vecs[i].e_cnt != 0));
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].e_cnt == 0));
      if (vecs[i].e_cnt != 0) chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(vecs[i].e_data));
    end
    m_cnt = 0; m_wr = 1; m_rd = 1; m_q.delete();

    // fill to full
    cycle(1'b0, 1'b0, 1'b1, 20'h0, dp, dq);
    for (int i = 0; i < 512; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 20'(i), dp, dq);
      if (i == 446) chk("af_below_448", int'(almost_full), 0);
      if (i == 447) chk("af_at_448", int'(almost_full), 1);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_in_ready", int'(in_ready), 0);
    chk("fill_count", int'(count), 512);
    cycle(1'b1, 1'b0, 1'b0, 20'h99999, dp, dq);
    chk("513th_not_written", int'(dp), 0);
    chk("full_head", int'(out_data), 0);
    cycle(1'b1, 1'b1, 1'b0, 20'h77777, dp, dq);
    chk("full_pop_count", int'(count), 511);
    chk("full_pop_in_ready", int'(in_ready), 1);
    chk("full_pop_head", int'(out_data), 1);

    // simultaneous push/pop at count=5
    cycle(1'b0, 1'b0, 1'b1, 20'h0, dp, dq);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 20'(20'h100 + i), dp, dq);
    ra0 = int'(mem_ra); wa0 = int'(mem_wa);
    cycle(1'b1, 1'b1, 1'b0, 20'h00555, dp, dq);
    chk("pp_count", int'(count), 5);
    chk("pp_ra_adv", int'(mem_ra), ra0 + 1);
    chk("pp_wa_adv", int'(mem_wa), wa0 + 1);

    // random traffic, 2000 words through
    cycle(1'b0, 1'b0, 1'b1, 20'h0, dp, dq);
    pushed = 0; popped = 0; cyc = 0; ra_wraps = 0; wa_wraps = 0;
    prev_ra = int'(mem_ra); prev_wa = int'(mem_wa);
    while ((pushed < 2000 || popped < 2000) && cyc < 20000) begin
      cycle((pushed < 2000) && ($urandom_range(0, 3) != 0), $urandom_range(0, 2) != 0, 1'b0,
            20'($urandom), dp, dq);
      if (dp) pushed++;
      if (dq) popped++;
      if (prev_ra == 511 && int'(mem_ra) == 0) ra_wraps++;
      if (prev_wa == 511 && int'(mem_wa) == 0) wa_wraps++;
      prev_ra = int'(mem_ra); prev_wa = int'(mem_wa);
      cyc++;
    end
    chk("rand_completed", int'(cyc < 20000), 1);
    chk("rand_popped", popped, 2000);
    chk("rand_ra_wraps_ge3", int'(ra_wraps >= 3), 1);
    chk("rand_wa_wraps_ge3", int'(wa_wraps >= 3), 1);

    // flush at count=37 with both handshakes asserted
    for (int i = 0; i < 37; i++) cycle(1'b1, 1'b0, 1'b0, 20'(20'h200 + i), dp, dq);
    chk("pre_flush_count", int'(count), 37);
    cycle(1'b1, 1'b1, 1'b1, 20'h0F0F0, dp, dq);
    chk("flush_no_write", int'(dp), 0);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);

    // asynchronous reset mid-fill at count=100
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'b0, 20'(20'h300 + i), dp, dq);
    chk("pre_rst_count", int'(count), 100);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_empty", int'(empty), 1);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_mem_wa", int'(mem_wa), 0);
    cycle(1'b1, 1'b0, 1'b0, 20'h55555, dp, dq);
    chk("post_rst_pushed", int'(dp), 1);
    chk("post_rst_head", int'(out_data), 20'h55555);
    cycle(1'b0, 1'b1, 1'b0, 20'h0, dp, dq);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
